timer_irq_periph: RTL and testbench



---
 rtl/timer_pkg.sv | 45 ++++
 rtl/timer_prescaler.sv | 31 +++
 rtl/timer_irq_periph.sv | 131 +++++++++++++
 tb/tb_timer_irq_periph.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared register offsets, CTRL layout and access encodings for the machine-timer peripheral.
package timer_pkg;

  // Word offsets within the 32-byte window, indexed by addr[4:2].
  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_PRESCALE = 3'd1;
  localparam logic [2:0] OFF_MTIME_LO = 3'd2;
  localparam logic [2:0] OFF_MTIME_HI = 3'd3;
  localparam logic [2:0] OFF_CMP_LO   = 3'd4;
  localparam logic [2:0] OFF_CMP_HI   = 3'd5;
  localparam logic [2:0] OFF_STATUS   = 3'd6;
  localparam logic [2:0] OFF_RSVD     = 3'd7;

  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_IRQ_EN   = 1;
  localparam int unsigned CTRL_AUTO_CLR = 2;
  localparam int unsigned CTRL_WIDTH    = 3;

  localparam logic [2:0] MEM_WORD = 3'b010;

  // Field order puts en at bit 0 so the struct maps directly onto the register word.
  typedef struct packed {
    logic auto_clr;
    logic irq_en;
    logic en;
  } ctrl_t;

  function automatic ctrl_t ctrl_from_word(input logic [31:0] word);
    ctrl_t c;
    c.en       = word[CTRL_EN];
    c.irq_en   = word[CTRL_IRQ_EN];
    c.auto_clr = word[CTRL_AUTO_CLR];
    return c;
  endfunction

  function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
    logic [31:0] word;
    word                = '0;
    word[CTRL_EN]       = c.en;
    word[CTRL_IRQ_EN]   = c.irq_en;
    word[CTRL_AUTO_CLR] = c.auto_clr;
    return word;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for mtime: pcnt runs 0..prescale while enabled and emits one tick at the top.
module timer_prescaler (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] prescale,
  input  logic        restart,
  output logic        tick
);

  logic [15:0] pcnt_q, pcnt_d;

  assign tick = en && (pcnt_q == prescale);

  always_comb begin
    pcnt_d = pcnt_q + 16'd1;
    // A PRESCALE write restarts the count so a smaller period never overshoots.
    if (restart || !en || tick) begin
      pcnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/timer_irq_periph.sv
// Memory-mapped machine timer: prescaled 64-bit mtime, 64-bit compare, sticky pending and
// registered level interrupt, sharing the core's load/store port with data_mem.
module timer_irq_periph
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter logic [15:0] PRESCALE_RST = 16'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [2:0]  mem_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        tm_interupt
);

  ctrl_t       ctrl_q, ctrl_d;
  logic [15:0] prescale_q, prescale_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] cmp_q, cmp_d;
  logic [31:0] shadow_q, shadow_d;
  logic        pending_q, pending_d;
  logic        irq_q, irq_d;

  logic [2:0]  offset;
  logic        wr_acc, rd_acc;
  logic        wr_ctrl, wr_prescale, wr_mtime_lo, wr_mtime_hi;
  logic        wr_cmp_lo, wr_cmp_hi, wr_status;
  logic        tick, match;

  logic unused_addr;
  assign unused_addr = ^addr[1:0];

  assign sel    = (addr[31:5] == BASE_ADDR[31:5]);
  assign offset = addr[4:2];
  assign wr_acc = sel && wr_en && (mem_type == MEM_WORD);
  assign rd_acc = sel && rd_en;

  assign wr_ctrl     = wr_acc && (offset == OFF_CTRL);
  assign wr_prescale = wr_acc && (offset == OFF_PRESCALE);
  assign wr_mtime_lo = wr_acc && (offset == OFF_MTIME_LO);
  assign wr_mtime_hi = wr_acc && (offset == OFF_MTIME_HI);
  assign wr_cmp_lo   = wr_acc && (offset == OFF_CMP_LO);
  assign wr_cmp_hi   = wr_acc && (offset == OFF_CMP_HI);
  assign wr_status   = wr_acc && (offset == OFF_STATUS);

  assign match = (mtime_q >= cmp_q);

  timer_prescaler u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (ctrl_q.en),
    .prescale (prescale_q),
    .restart  (wr_prescale),
    .tick     (tick)
  );

  always_comb begin
    ctrl_d     = wr_ctrl ? ctrl_from_word(wdata) : ctrl_q;
    prescale_d = wr_prescale ? wdata[15:0] : prescale_q;

    mtime_d = mtime_q;
    if (tick) begin
      mtime_d = (match && ctrl_q.auto_clr) ? 64'd0 : mtime_q + 64'd1;
    end
    // Software writes beat the tick; the untouched half keeps its pre-edge value.
    if (wr_mtime_lo) begin
      mtime_d = {mtime_q[63:32], wdata};
    end
    if (wr_mtime_hi) begin
      mtime_d = {wdata, mtime_q[31:0]};
    end

    cmp_d = cmp_q;
    if (wr_cmp_lo) begin
      cmp_d = {cmp_q[63:32], wdata};
    end
    if (wr_cmp_hi) begin
      cmp_d = {wdata, cmp_q[31:0]};
    end

    shadow_d = (rd_acc && (offset == OFF_MTIME_LO)) ? mtime_q[63:32] : shadow_q;

    // A live match re-asserts pending even on the edge it is being cleared.
    pending_d = match || (pending_q && !(wr_status && wdata[0]));
    irq_d     = pending_q && ctrl_q.irq_en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q     <= '0;
      prescale_q <= PRESCALE_RST;
      mtime_q    <= '0;
      cmp_q      <= '1;
      shadow_q   <= '0;
      pending_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      mtime_q    <= mtime_d;
      cmp_q      <= cmp_d;
      shadow_q   <= shadow_d;
      pending_q  <= pending_d;
      irq_q      <= irq_d;
    end
  end

  assign tm_interupt = irq_q;

  always_comb begin
    rdata = '0;
    if (rd_acc) begin
      case (offset)
        OFF_CTRL:     rdata = ctrl_to_word(ctrl_q);
        OFF_PRESCALE: rdata = {16'd0, prescale_q};
        OFF_MTIME_LO: rdata = mtime_q[31:0];
        OFF_MTIME_HI: rdata = shadow_q;
        OFF_CMP_LO:   rdata = cmp_q[31:0];
        OFF_CMP_HI:   rdata = cmp_q[63:32];
        OFF_STATUS:   rdata = {31'd0, pending_q};
        default:      rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_irq_periph.sv
// Directed bench for timer_irq_periph; expected values queue up as each access is driven.
module tb_timer_irq_periph;
  import timer_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [2:0]  mem_type;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        sel;
  logic        tm_interupt;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          n_chk;
  int          n_pass;
  int          n_fail;

  timer_irq_periph #(
    .BASE_ADDR    (BASE),
    .PRESCALE_RST (16'd0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en),
    .wr_en       (wr_en),
    .mem_type    (mem_type),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .sel         (sel),
    .tm_interupt (tm_interupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] reg_addr(input logic [2:0] off);
    return BASE + {27'd0, off, 2'b00};
  endfunction

  // Pops the oldest expectation and compares the observed value against it.
  task automatic compare(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_chk++;
    assert (obs === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", t, obs, e);
    end
  endtask

  task automatic expect_val(input logic [31:0] e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  // Each access drives at a negedge and crosses exactly one posedge.
  task automatic wr(input logic [2:0] off, input logic [31:0] d, input logic [2:0] mt);
    @(negedge clk);
    wr_en    = 1'b1;
    mem_type = mt;
    addr     = reg_addr(off);
    wdata    = d;
    @(posedge clk);
    #1;
    wr_en    = 1'b0;
    mem_type = MEM_WORD;
  endtask

  task automatic rd(input logic [2:0] off, input logic [31:0] e, input string t);
    @(negedge clk);
    rd_en = 1'b1;
    addr  = reg_addr(off);
    expect_val(e, t);
    #1;
    compare(rdata);
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  task automatic irq_chk(input logic e, input string t);
    expect_val({31'd0, e}, t);
    compare({31'd0, tm_interupt});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    n_fail   = 0;
    rst      = 1'b1;
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    mem_type = MEM_WORD;
    addr     = '0;
    wdata    = '0;
    idle(2);
    rst = 1'b0;

    // Reset state
    rd(OFF_MTIME_LO, 32'h0, "rst_mtime_lo");
    rd(OFF_MTIME_HI, 32'h0, "rst_mtime_hi");
    rd(OFF_STATUS, 32'h0, "rst_status");
    rd(OFF_CMP_LO, 32'hFFFF_FFFF, "rst_cmp_lo");
    rd(OFF_CMP_HI, 32'hFFFF_FFFF, "rst_cmp_hi");
    irq_chk(1'b0, "rst_irq");

    // Prescaler: period 4, 40 enabled edges -> 10 ticks
    wr(OFF_PRESCALE, 32'd3, MEM_WORD);
    wr(OFF_CTRL, 32'd1, MEM_WORD);
    idle(39);
    wr(OFF_CTRL, 32'd0, MEM_WORD);
    rd(OFF_MTIME_LO, 32'd10, "presc_mtime");
    rd(OFF_PRESCALE, 32'd3, "presc_reg");
    wr(OFF_CTRL, 32'd1, 3'b000);
    idle(8);
    rd(OFF_CTRL, 32'd0, "byte_store_ctrl");
    rd(OFF_MTIME_LO, 32'd10, "byte_store_mtime");

    // Interrupt: cmp = 5, one tick per clock
    wr(OFF_MTIME_LO, 32'd0, MEM_WORD);
    wr(OFF_PRESCALE, 32'd0, MEM_WORD);
    wr(OFF_CMP_HI, 32'd0, MEM_WORD);
    wr(OFF_CMP_LO, 32'd5, MEM_WORD);
    wr(OFF_CTRL, 32'd3, MEM_WORD);
    idle(5);
    rd(OFF_STATUS, 32'd0, "pend_before_match_edge");
    irq_chk(1'b0, "irq_lag");
    rd(OFF_STATUS, 32'd1, "pend_set");
    irq_chk(1'b1, "irq_rise");
    wr(OFF_STATUS, 32'd1, MEM_WORD);
    rd(OFF_STATUS, 32'd1, "w1c_loses_to_match");
    wr(OFF_CMP_HI, 32'd1, MEM_WORD);
    wr(OFF_STATUS, 32'd1, MEM_WORD);
    irq_chk(1'b1, "irq_before_fall");
    rd(OFF_STATUS, 32'd0, "w1c_clears");
    irq_chk(1'b0, "irq_fall");
    wr(OFF_CTRL, 32'd0, MEM_WORD);

    // Carry into the high word and shadow coherence
    wr(OFF_MTIME_HI, 32'd0, MEM_WORD);
    wr(OFF_MTIME_LO, 32'hFFFF_FFFE, MEM_WORD);
    wr(OFF_CMP_HI, 32'hFFFF_FFFF, MEM_WORD);
    wr(OFF_CTRL, 32'd1, MEM_WORD);
    idle(1);
    wr(OFF_CTRL, 32'd0, MEM_WORD);
    rd(OFF_MTIME_LO, 32'd0, "carry_lo");
    rd(OFF_MTIME_HI, 32'd1, "carry_hi");
    wr(OFF_MTIME_HI, 32'd5, MEM_WORD);
    rd(OFF_MTIME_HI, 32'd1, "stale_shadow");
    rd(OFF_MTIME_LO, 32'd0, "relatch_lo");
    rd(OFF_MTIME_HI, 32'd5, "relatch_hi");

    // AUTO_CLR with cmp = 3
    wr(OFF_MTIME_HI, 32'd0, MEM_WORD);
    wr(OFF_CMP_HI, 32'd0, MEM_WORD);
    wr(OFF_CMP_LO, 32'd3, MEM_WORD);
    wr(OFF_CTRL, 32'd7, MEM_WORD);
    rd(OFF_MTIME_LO, 32'd0, "autoclr_0");
    rd(OFF_MTIME_LO, 32'd1, "autoclr_1");
    rd(OFF_MTIME_LO, 32'd2, "autoclr_2");
    rd(OFF_MTIME_LO, 32'd3, "autoclr_3");
    rd(OFF_MTIME_LO, 32'd0, "autoclr_wrap");
    rd(OFF_MTIME_LO, 32'd1, "autoclr_1b");
    rd(OFF_MTIME_LO, 32'd2, "autoclr_2b");
    irq_chk(1'b1, "autoclr_irq");
    rd(OFF_STATUS, 32'd1, "autoclr_pend");

    // Write wins over a simultaneous tick
    wr(OFF_CMP_HI, 32'hFFFF_FFFF, MEM_WORD);
    wr(OFF_CTRL, 32'd3, MEM_WORD);
    wr(OFF_MTIME_LO, 32'd100, MEM_WORD);
    rd(OFF_MTIME_LO, 32'd100, "collide_lo");
    rd(OFF_MTIME_HI, 32'd0, "collide_hi");

    // Asynchronous reset mid-count
    wr(OFF_PRESCALE, 32'd3, MEM_WORD);
    idle(3);
    irq_chk(1'b1, "irq_before_rst");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    irq_chk(1'b0, "irq_async_rst");
    #1;
    rst = 1'b0;
    rd(OFF_MTIME_HI, 32'd0, "post_rst_shadow");
    rd(OFF_CTRL, 32'd0, "post_rst_ctrl");
    rd(OFF_PRESCALE, 32'd0, "post_rst_prescale");
    rd(OFF_CMP_LO, 32'hFFFF_FFFF, "post_rst_cmp_lo");
    rd(OFF_CMP_HI, 32'hFFFF_FFFF, "post_rst_cmp_hi");
    rd(OFF_STATUS, 32'd0, "post_rst_status");
    idle(4);
    rd(OFF_MTIME_LO, 32'd0, "post_rst_mtime");

    // Decode corners
    wr(OFF_RSVD, 32'hDEAD_BEEF, MEM_WORD);
    rd(OFF_RSVD, 32'd0, "reserved");
    @(negedge clk);
    addr  = reg_addr(OFF_CMP_LO);
    rd_en = 1'b0;
    #1;
    expect_val(32'd0, "rdata_no_rd_en");
    compare(rdata);
    expect_val(32'd1, "sel_in_window");
    compare({31'd0, sel});
    addr  = BASE + 32'h20;
    rd_en = 1'b1;
    #1;
    expect_val(32'd0, "sel_out_window");
    compare({31'd0, sel});
    expect_val(32'd0, "rdata_out_window");
    compare(rdata);
    rd_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
